// File: rtl/prod_acc_if.sv
// rtl/prod_acc_if.sv - upstream/downstream handshake bundle for prod_acc
// Signal mx exists only when ACC_MAX_EN is defined.
interface prod_acc_if;
  logic        dav_in_;
  logic [15:0] m;
  logic        rfd_in;
  logic        rfd_out;
  logic        dav_out_;
  logic [23:0] s;
`ifdef ACC_MAX_EN
  logic [15:0] mx;

  modport master (output dav_in_, m, rfd_out, input rfd_in, dav_out_, s, mx);
  modport slave  (input dav_in_, m, rfd_out, output rfd_in, dav_out_, s, mx);
`else
  modport master (output dav_in_, m, rfd_out, input rfd_in, dav_out_, s);
  modport slave  (input dav_in_, m, rfd_out, output rfd_in, dav_out_, s);
`endif
endinterface

// File: rtl/prod_acc.sv
// rtl/prod_acc.sv - sums N_TERMS unsigned 16-bit products per batch over dav/rfd handshakes
// Optional feature macro ACC_MAX_EN adds the batch-maximum register MAX and output mx.
module prod_acc #(
  parameter int N_TERMS = 4
) (
  input  logic      clock,
  input  logic      reset_,
  prod_acc_if.slave bus
);
  typedef enum logic [1:0] {IN_WAIT, IN_ACK, OUT_REQ, OUT_ACK} state_t;

  localparam logic [8:0] CNT_LAST = 9'(N_TERMS);

  state_t      state, state_nx;
  logic [23:0] acc, acc_nx;
  logic [23:0] s_q, s_nx;
  logic [8:0]  cnt, cnt_nx;
  logic        rfd_q, rfd_nx;
  logic        dav_q, dav_nx;
`ifdef ACC_MAX_EN
  logic [15:0] max_q, max_nx;
  logic [15:0] mx_q, mx_nx;
`endif

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      state <= IN_WAIT;
      acc   <= '0;
      s_q   <= '0;
      cnt   <= '0;
      rfd_q <= 1'b1;
      dav_q <= 1'b1;
`ifdef ACC_MAX_EN
      max_q <= '0;
      mx_q  <= '0;
`endif
    end else begin
      state <= state_nx;
      acc   <= acc_nx;
      s_q   <= s_nx;
      cnt   <= cnt_nx;
      rfd_q <= rfd_nx;
      dav_q <= dav_nx;
`ifdef ACC_MAX_EN
      max_q <= max_nx;
      mx_q  <= mx_nx;
`endif
    end
  end

  // Leaving IN_WAIT on every accept means a long dav_in_ low adds m only once.
  always_comb begin
    state_nx = state;
    acc_nx   = acc;
    s_nx     = s_q;
    cnt_nx   = cnt;
    rfd_nx   = rfd_q;
    dav_nx   = dav_q;
`ifdef ACC_MAX_EN
    max_nx   = max_q;
    mx_nx    = mx_q;
`endif
    case (state)
      IN_WAIT: begin
        if (!bus.dav_in_) begin
          acc_nx   = acc + {8'd0, bus.m};
          cnt_nx   = cnt + 9'd1;
          rfd_nx   = 1'b0;
          state_nx = IN_ACK;
`ifdef ACC_MAX_EN
          max_nx   = (bus.m > max_q) ? bus.m : max_q;
`endif
        end
      end
      IN_ACK: begin
        // cnt stops at CNT_LAST because the batch is closed here, so it never wraps.
        if (bus.dav_in_) begin
          if (cnt == CNT_LAST) begin
            state_nx = OUT_REQ;
          end else begin
            rfd_nx   = 1'b1;
            state_nx = IN_WAIT;
          end
        end
      end
      OUT_REQ: begin
        if (bus.rfd_out) begin
          s_nx     = acc;
          dav_nx   = 1'b0;
          state_nx = OUT_ACK;
`ifdef ACC_MAX_EN
          mx_nx    = max_q;
`endif
        end
      end
      OUT_ACK: begin
        if (!bus.rfd_out) begin
          dav_nx   = 1'b1;
          acc_nx   = '0;
          cnt_nx   = '0;
          rfd_nx   = 1'b1;
          state_nx = IN_WAIT;
`ifdef ACC_MAX_EN
          max_nx   = '0;
`endif
        end
      end
      default: state_nx = IN_WAIT;
    endcase
  end

  assign bus.rfd_in   = rfd_q;
  assign bus.dav_out_ = dav_q;
  assign bus.s        = s_q;
`ifdef ACC_MAX_EN
  assign bus.mx       = mx_q;
`endif

endmodule
